// File: rtl/mrfm_acq_pkg.sv
// ---------------------------------------------------------------
// mrfm_acq_pkg: shared constants and state encoding. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package mrfm_acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic [6:0] ADDR_CFG_DEFAULT  = 7'd56;
  localparam logic [6:0] ADDR_CTRL_DEFAULT = 7'd57;
  localparam int         ARM_BIT           = 0;
  localparam int         ABORT_BIT         = 1;

endpackage

`default_nettype wire

// File: rtl/mrfm_frame_counter.sv
// ---------------------------------------------------------------
// mrfm_frame_counter: 16-bit strobe counter with terminal compare. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module mrfm_frame_counter #(
  parameter bit ZERO_IS_ONE = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic        count_en,
  input  logic        strobe,
  input  logic [15:0] len_in,
  output logic        term,
  output logic        len_zero
);

  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    len_d = len_q;
    if (load)
      len_d = (ZERO_IS_ONE && (len_in == 16'd0)) ? 16'd1 : len_in;

    // 17-bit compare so a length of 65535 cannot wrap before matching
    term = count_en && strobe &&
           (({1'b0, cnt_q} + 17'd1) == {1'b0, len_q});

    cnt_d = cnt_q;
    if (load || clear || term)
      cnt_d = 16'd0;
    else if (count_en && strobe)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      len_q <= 16'd0;
      cnt_q <= 16'd0;
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end

  assign len_zero = (len_q == 16'd0);

endmodule

`default_nettype wire

// File: rtl/setting_reg.sv
// ---------------------------------------------------------------
// setting_reg: reset-to-0 register on the serial settings bus. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module setting_reg #(
  parameter logic [6:0] MY_ADDR = 7'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        strobe,
  input  logic [6:0]  addr,
  input  logic [31:0] in,
  output logic [31:0] out
);

  logic [31:0] out_q, out_d;

  always_comb begin
    out_d = out_q;
    if (strobe && (addr == MY_ADDR))
      out_d = in;
  end

  always_ff @(posedge clock) begin
    if (reset) out_q <= 32'd0;
    else       out_q <= out_d;
  end

  assign out = out_q;

endmodule

`default_nettype wire

// File: rtl/mrfm_acq_ctrl.sv
// ---------------------------------------------------------------
// mrfm_acq_ctrl: sync-aligned frame acquisition sequencer. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module mrfm_acq_ctrl
  import mrfm_acq_pkg::*;
#(
  parameter logic [6:0] ADDR_CFG  = ADDR_CFG_DEFAULT,
  parameter logic [6:0] ADDR_CTRL = ADDR_CTRL_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        serial_strobe,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        sync_in,
  input  logic        strobe_in,
  output logic        strobe_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] frames_done,
  output logic [2:0]  state_dbg
);

  state_t      state_q, state_d;
  logic        sync_dly_q;
  logic        done_q, done_d;
  logic [15:0] frames_done_q, frames_done_d;
  logic [15:0] nframes_q, nframes_d;
  logic [31:0] cfg;

  logic ctrl_wr, arm_req, abort_req, load, sync_edge;
  logic settle_term, settle_zero, cap_term;
  logic cap_len_zero_unused;
  logic unused_ctrl_bits;

  setting_reg #(.MY_ADDR(ADDR_CFG)) u_cfg (
    .clock  (clock),
    .reset  (reset),
    .strobe (serial_strobe),
    .addr   (serial_addr),
    .in     (serial_data),
    .out    (cfg)
  );

  assign ctrl_wr   = serial_strobe && (serial_addr == ADDR_CTRL);
  assign arm_req   = ctrl_wr && serial_data[ARM_BIT];
  assign abort_req = (ctrl_wr && serial_data[ABORT_BIT]) || !enable;
  assign load      = (state_q == ST_IDLE) && arm_req && !abort_req;
  assign sync_edge = sync_in && !sync_dly_q;
  assign unused_ctrl_bits = ^serial_data[15:2];

  mrfm_frame_counter #(.ZERO_IS_ONE(1'b0)) u_settle_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .clear    (abort_req),
    .count_en (state_q == ST_SETTLE),
    .strobe   (strobe_in),
    .len_in   (cfg[15:0]),
    .term     (settle_term),
    .len_zero (settle_zero)
  );

  mrfm_frame_counter #(.ZERO_IS_ONE(1'b1)) u_sample_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .clear    (abort_req),
    .count_en (state_q == ST_CAPTURE),
    .strobe   (strobe_in),
    .len_in   (cfg[31:16]),
    .term     (cap_term),
    .len_zero (cap_len_zero_unused)
  );

  always_comb begin
    state_d       = state_q;
    done_d        = done_q;
    frames_done_d = frames_done_q;
    nframes_d     = nframes_q;

    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d       = ST_WAIT_SYNC;
          done_d        = 1'b0;
          frames_done_d = 16'd0;
          nframes_d     = serial_data[31:16];
        end
      end
      ST_WAIT_SYNC: begin
        if (sync_edge)
          state_d = settle_zero ? ST_CAPTURE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_term)
          state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (cap_term) begin
          if (frames_done_q != 16'hFFFF)
            frames_done_d = frames_done_q + 16'd1;
          if ((nframes_q != 16'd0) &&
              (({1'b0, frames_done_q} + 17'd1) == {1'b0, nframes_q})) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WAIT_SYNC;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including a completing strobe
    if (abort_req) begin
      state_d       = ST_IDLE;
      done_d        = done_q;
      frames_done_d = frames_done_q;
      nframes_d     = nframes_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      sync_dly_q    <= 1'b0;
      done_q        <= 1'b0;
      frames_done_q <= 16'd0;
      nframes_q     <= 16'd0;
    end else begin
      state_q       <= state_d;
      sync_dly_q    <= sync_in;
      done_q        <= done_d;
      frames_done_q <= frames_done_d;
      nframes_q     <= nframes_d;
    end
  end

  assign strobe_out  = strobe_in && (state_q == ST_CAPTURE) && !reset;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign frames_done = frames_done_q;
  assign state_dbg   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mrfm_acq_ctrl.sv
// ---------------------------------------------------------------
// tb_mrfm_acq_ctrl: scoreboard bench for mrfm_acq_ctrl. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_mrfm_acq_ctrl;

  localparam logic [6:0] A_CFG  = 7'd56;
  localparam logic [6:0] A_CTRL = 7'd57;

  logic        clk = 1'b0;
  logic        reset, enable, serial_strobe, sync_in, strobe_in;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        strobe_out, busy, done;
  logic [15:0] frames_done;
  logic [2:0]  state_dbg;

  int tests_run = 0;
  int fails     = 0;
  int tag       = 0;
  int cur_tag   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  mrfm_acq_ctrl dut (
    .clock         (clk),
    .reset         (reset),
    .enable        (enable),
    .serial_strobe (serial_strobe),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .sync_in       (sync_in),
    .strobe_in     (strobe_in),
    .strobe_out    (strobe_out),
    .busy          (busy),
    .done          (done),
    .frames_done   (frames_done),
    .state_dbg     (state_dbg)
  );

  // Monitor: every strobe_out pulse must match the next expected strobe tag
  always @(negedge clk) begin
    if (strobe_out) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL strobe_out: unexpected pulse on tag %0d, required none", cur_tag);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (e != cur_tag) begin
          fails++;
          $display("FAIL strobe_out: pulse on tag %0d, required tag %0d", cur_tag, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    serial_strobe = 1'b1;
    serial_addr   = a;
    serial_data   = d;
    cyc();
    serial_strobe = 1'b0;
    serial_data   = 32'd0;
  endtask

  task automatic strobe(input bit pass);
    tag++;
    cur_tag   = tag;
    strobe_in = 1'b1;
    if (pass) exp_q.push_back(tag);
    cyc();
    strobe_in = 1'b0;
    cyc();
  endtask

  task automatic sync_pulse();
    sync_in = 1'b1;
    cyc();
    sync_in = 1'b0;
    cyc();
  endtask

  task automatic drained(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; serial_strobe = 1'b0; serial_addr = 7'd0;
    serial_data = 32'd0; sync_in = 1'b0; strobe_in = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check("reset_state", state_dbg, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_frames", frames_done, 0);

    // Basic frame: settle 2, frame 4, one frame
    wr(A_CFG, {16'd4, 16'd2});
    wr(A_CTRL, {16'd1, 16'h0001});
    check("t1_busy_after_arm", busy, 1);
    check("t1_wait_sync", state_dbg, 1);
    sync_pulse();
    for (int i = 1; i <= 8; i++) strobe(i >= 3 && i <= 6);
    drained("t1_pulses");
    check("t1_done", done, 1);
    check("t1_frames", frames_done, 1);
    check("t1_busy", busy, 0);

    // Multi-frame: frame 3, no settle, three frames
    wr(A_CFG, {16'd3, 16'd0});
    wr(A_CTRL, {16'd3, 16'h0001});
    check("t2_done_cleared", done, 0);
    check("t2_frames_cleared", frames_done, 0);
    for (int f = 1; f <= 3; f++) begin
      strobe(1'b0);
      sync_pulse();
      for (int i = 1; i <= 5; i++) strobe(i <= 3);
      check("t2_frames", frames_done, f);
      check("t2_done", done, (f == 3) ? 1 : 0);
    end
    drained("t2_pulses");
    check("t2_idle", state_dbg, 0);

    // Sync held high at arm; edge during capture ignored
    sync_in = 1'b1;
    cyc(); cyc();
    wr(A_CFG, {16'd4, 16'd0});
    wr(A_CTRL, {16'd1, 16'h0001});
    strobe(1'b0); strobe(1'b0);
    check("t3_still_waiting", state_dbg, 1);
    sync_in = 1'b0; cyc();
    sync_in = 1'b1; cyc();
    check("t3_capture", state_dbg, 3);
    strobe(1'b1); strobe(1'b1);
    sync_in = 1'b0; cyc();
    sync_in = 1'b1; cyc();
    strobe(1'b1); strobe(1'b1);
    sync_in = 1'b0;
    strobe(1'b0);
    drained("t3_pulses");
    check("t3_frames", frames_done, 1);
    check("t3_done", done, 1);

    // Abort mid-capture, then a full re-run
    wr(A_CTRL, {16'd1, 16'h0001});
    sync_pulse();
    strobe(1'b1); strobe(1'b1);
    wr(A_CTRL, 32'h0000_0002);
    check("t4_abort_idle", state_dbg, 0);
    check("t4_abort_busy", busy, 0);
    strobe(1'b0); strobe(1'b0);
    check("t4_abort_done", done, 0);
    check("t4_abort_frames", frames_done, 0);
    wr(A_CTRL, {16'd1, 16'h0001});
    sync_pulse();
    for (int i = 1; i <= 4; i++) strobe(1'b1);
    drained("t4_pulses");
    check("t4_rerun_done", done, 1);
    check("t4_rerun_frames", frames_done, 1);

    // Arm+abort together from idle stays idle
    wr(A_CTRL, {16'd1, 16'h0003});
    check("t5_armabort_busy", busy, 0);
    check("t5_armabort_state", state_dbg, 0);

    // Arm while busy is ignored: no restart, no config reload
    wr(A_CFG, {16'd2, 16'd0});
    wr(A_CTRL, {16'd2, 16'h0001});
    sync_pulse();
    strobe(1'b1); strobe(1'b1);
    wr(A_CFG, {16'd5, 16'd0});
    wr(A_CTRL, {16'd2, 16'h0001});
    check("t5_busy_arm_frames", frames_done, 1);
    check("t5_busy_arm_busy", busy, 1);
    sync_pulse();
    strobe(1'b1); strobe(1'b1);
    drained("t5_pulses");
    check("t5_done", done, 1);
    check("t5_frames", frames_done, 2);

    // Continuous mode, frame 1 (config 5 latched above is replaced here)
    wr(A_CFG, {16'd1, 16'd0});
    wr(A_CTRL, {16'd0, 16'h0001});
    for (int i = 0; i < 20; i++) begin
      sync_pulse();
      strobe(1'b1);
    end
    drained("t6_pulses");
    check("t6_frames", frames_done, 20);
    check("t6_done", done, 0);
    check("t6_busy", busy, 1);
    enable = 1'b0;
    cyc();
    check("t6_disable_state", state_dbg, 0);
    enable = 1'b1;
    check("t6_frames_hold", frames_done, 20);

    // Abort on the final capture strobe: pulse passes, done stays 0
    wr(A_CTRL, {16'd1, 16'h0001});
    sync_pulse();
    tag++;
    cur_tag = tag;
    exp_q.push_back(tag);
    strobe_in = 1'b1;
    wr(A_CTRL, 32'h0000_0002);
    strobe_in = 1'b0;
    cyc();
    drained("t7_pulses");
    check("t7_done", done, 0);
    check("t7_state", state_dbg, 0);

    // Reset mid-capture with a strobe present
    wr(A_CTRL, {16'd1, 16'h0001});
    sync_pulse();
    tag++;
    cur_tag   = tag;
    strobe_in = 1'b1;
    reset     = 1'b1;
    cyc();
    strobe_in = 1'b0;
    reset     = 1'b0;
    cyc();
    drained("t8_pulses");
    check("t8_state", state_dbg, 0);
    check("t8_busy", busy, 0);
    check("t8_done", done, 0);
    check("t8_frames", frames_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mrfm_acq_ctrl.md
Name: mrfm_acq_ctrl

Overview:
Acquisition sequencer for the MRFM receive path. Sits between mrfm_proc and rx_buffer: it gates the mrfm_proc sample strobe so that rx_buffer captures only fixed-length frames aligned to the cantilever sync (sync_out). Each frame starts after a programmable settle interval. The block is configured and armed over the serial settings bus.

Parameters:
ADDR_CFG, 7'd56, serial address of config register: [15:0] settle_len (strobes), [31:16] frame_len (samples)
ADDR_CTRL, 7'd57, serial address of control register: bit0 arm, bit1 abort, [31:16] num_frames (0 = run until abort)

Ports:
clock  in  1  master clock (clk64)
reset  in  1  synchronous, active-high reset (rx_dsp_reset)
enable  in  1  enable_rx; low forces abort
serial_strobe  in  1  settings write strobe
serial_addr  in  7  settings address
serial_data  in  32  settings data
sync_in  in  1  mrfm_proc sync_out, level
strobe_in  in  1  mrfm_proc strobe_out, 1-cycle pulses
strobe_out  out  1  gated strobe to rx_buffer rxstrobe
busy  out  1  high in any state except IDLE
done  out  1  sticky; set on completion of num_frames, cleared by arm or reset
frames_done  out  16  completed frames since last arm, saturates at 16'hFFFF
state_dbg  out  3  current state encoding, for debug bus

Behaviour:
- Reset: state IDLE; all counters, config and control registers 0; strobe_out=0, busy=0, done=0, frames_done=0, sync_d=0.
- Config write (serial_strobe && addr==ADDR_CFG): latched in any state, but takes effect only at the next arm. Active copies settle_r, frame_r, nframes_r are loaded at arm.
- frame_len=0 is treated as 1. settle_len=0 means SETTLE is skipped.
- Sync edge: sync_d <= sync_in every cycle; edge = sync_in & ~sync_d. Edge is evaluated only in WAIT_SYNC and ignored in other states.
- strobe_out = strobe_in & (state==CAPTURE). Combinational, zero latency, so it stays aligned with i/q/ip/qp.
- States: IDLE=0, WAIT_SYNC=1, SETTLE=2, CAPTURE=3, DONE=4.
- IDLE: on ctrl write with arm=1, abort=0 and enable=1: clear done, frames_done, sample_cnt and settle_cnt; load active config; next state WAIT_SYNC.
- WAIT_SYNC: on edge, go to SETTLE if settle_r!=0, else CAPTURE.
- SETTLE: count strobe_in. On the strobe that makes settle_cnt==settle_r, go to CAPTURE and clear settle_cnt.
- CAPTURE: count strobe_in. On the strobe that makes sample_cnt==frame_r:
  - clear sample_cnt; increment frames_done (saturating);
  - if nframes_r!=0 and frames_done+1==nframes_r, go to DONE; else go to WAIT_SYNC.
- DONE: set done=1; go to IDLE next cycle. busy is high during DONE.
- Latency: arm write at cycle N gives busy=1 at N+1. Sync edge at cycle k gives state≠WAIT_SYNC at k+1. A strobe_in in the first CAPTURE cycle is passed through.
- Abort: ctrl write with abort=1, or enable=0, sends any state to IDLE next cycle. Counters are cleared, done is not set, frames_done holds.
- Simultaneous events:
  - Abort beats arm in the same write.
  - Arm while busy is ignored (no restart, config not reloaded).
  - A sync edge during SETTLE or CAPTURE is ignored.
  - Abort in the same cycle as the final capture strobe: strobe_out still pulses that cycle, the state goes to IDLE, done stays 0.
- reset mid-operation: same as the reset state above; no strobe_out in the reset cycle or after.
- Counters are 16 bits. A frame_len of 65535 must not wrap before the compare.

Decomposition:
- Shared package mrfm_acq_pkg holds: state encoding constants (5 states, 3 bits), ADDR_CFG/ADDR_CTRL defaults, and the ctrl bit positions ARM_BIT=0, ABORT_BIT=1.
- The config register uses the existing setting_reg (reset-to-0 register on the serial bus).
- Natural sub-module: mrfm_frame_counter. It is a 16-bit strobe counter with load/clear, a terminal-count compare output, and the frame_len==0→1 mapping. It is instantiated twice, for settle and capture.
- FSM and gating live in the top of mrfm_acq_ctrl.

Test Plan:
- Basic frame: cfg settle=2, frame=4, ctrl num_frames=1, arm; sync pulse; 8 strobes → strobe_out passes strobes 3–6 only, done=1, frames_done=1, busy=0.
- Multi-frame: frame=3, settle=0, num_frames=3, three sync edges with 5 strobes each → 9 strobe_out pulses, 3 per frame, none before each edge; done after the 3rd frame.
- Edge handling: sync held high at arm time → no capture until a low→high transition; a sync edge during CAPTURE does not restart the frame count.
- Abort mid-CAPTURE after 2 of 4 samples → state IDLE next cycle, no further strobe_out, done=0, frames_done=0. A following arm+sync captures a full 4.
- Arm+abort in same write from IDLE → stays IDLE, busy=0. Arm while busy → frames_done and config unchanged.
- Continuous (num_frames=0, frame=1): 20 sync edges → frames_done=20, done=0. Deassert enable → IDLE. Then reset → all outputs 0.
